// File: rtl/skin_frame_ctrl_if.sv
// Skin frame controller bus: host shadow writes, frame/pixel stream in,
// active bounds and per-frame statistics out.
// Inputs (master drives): wr_en, wr_addr, wr_data, vs, dval, skin.
// Outputs (slave drives): cb_min, cb_max, cr_min, cr_max, cfg_pending,
//   pix_count, skin_count, stat_valid.
interface skin_frame_ctrl_if #(
    parameter int CNT_W = 20
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             vs;
    logic             dval;
    logic             skin;
    logic [7:0]       cb_min;
    logic [7:0]       cb_max;
    logic [7:0]       cr_min;
    logic [7:0]       cr_max;
    logic             cfg_pending;
    logic [CNT_W-1:0] pix_count;
    logic [CNT_W-1:0] skin_count;
    logic             stat_valid;

    modport master (
        output wr_en, wr_addr, wr_data, vs, dval, skin,
        input  cb_min, cb_max, cr_min, cr_max,
        input  cfg_pending, pix_count, skin_count, stat_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, vs, dval, skin,
        output cb_min, cb_max, cr_min, cr_max,
        output cfg_pending, pix_count, skin_count, stat_valid
    );
endinterface

// File: rtl/skin_frame_ctrl.sv
// Frame-synchronous bounds/statistics controller for the YCbCr skin classifier.
// Ports: clk, rst (async, active-high), bus (skin_frame_ctrl_if.slave).
//   Shadow bounds are committed to the active outputs only at frame starts;
//   valid and skin pixels are counted per frame and reported on stat_valid.
module skin_frame_ctrl #(
    parameter int         CNT_W      = 20,
    parameter logic [7:0] CB_MIN_RST = 8'd85,
    parameter logic [7:0] CB_MAX_RST = 8'd127,
    parameter logic [7:0] CR_MIN_RST = 8'd132,
    parameter logic [7:0] CR_MAX_RST = 8'd155
) (
    input  logic               clk,
    input  logic               rst,
    skin_frame_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             commit;
    logic             report;
    logic             count_en;

    logic [7:0]       sh_cb_min;
    logic [7:0]       sh_cb_max;
    logic [7:0]       sh_cr_min;
    logic [7:0]       sh_cr_max;
    logic [7:0]       act_cb_min;
    logic [7:0]       act_cb_max;
    logic [7:0]       act_cr_min;
    logic [7:0]       act_cr_max;
    logic             pending;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] skin_cnt;
    logic [CNT_W-1:0] pix_out;
    logic [CNT_W-1:0] skin_out;
    logic             stat_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        report    = 1'b0;
        count_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.vs) begin
                    commit    = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // The pixel arriving alongside vs belongs to no frame.
                if (bus.vs) begin
                    report    = 1'b1;
                    state_nxt = REPORT;
                end else begin
                    count_en  = bus.dval;
                end
            end
            REPORT: begin
                commit    = 1'b1;
                state_nxt = ACTIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow writes land in any state; commit reads pre-write values
    // because both are sampled on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_cb_min <= CB_MIN_RST;
            sh_cb_max <= CB_MAX_RST;
            sh_cr_min <= CR_MIN_RST;
            sh_cr_max <= CR_MAX_RST;
        end else if (bus.wr_en) begin
            unique case (bus.wr_addr)
                2'd0: sh_cb_min <= bus.wr_data;
                2'd1: sh_cb_max <= bus.wr_data;
                2'd2: sh_cr_min <= bus.wr_data;
                2'd3: sh_cr_max <= bus.wr_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cb_min <= CB_MIN_RST;
            act_cb_max <= CB_MAX_RST;
            act_cr_min <= CR_MIN_RST;
            act_cr_max <= CR_MAX_RST;
        end else if (commit) begin
            act_cb_min <= sh_cb_min;
            act_cb_max <= sh_cb_max;
            act_cr_min <= sh_cr_min;
            act_cr_max <= sh_cr_max;
        end
    end

    // A write in the commit cycle keeps pending set for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              pending <= 1'b0;
        else if (bus.wr_en)   pending <= 1'b1;
        else if (commit)      pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            skin_cnt <= '0;
        end else if (commit) begin
            pix_cnt  <= '0;
            skin_cnt <= '0;
        end else if (count_en) begin
            if (pix_cnt != '1)
                pix_cnt <= pix_cnt + CNT_W'(1);
            if (bus.skin && skin_cnt != '1)
                skin_cnt <= skin_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out  <= '0;
            skin_out <= '0;
            stat_vld <= 1'b0;
        end else begin
            stat_vld <= report;
            if (report) begin
                pix_out  <= pix_cnt;
                skin_out <= skin_cnt;
            end
        end
    end

    assign bus.cb_min      = act_cb_min;
    assign bus.cb_max      = act_cb_max;
    assign bus.cr_min      = act_cr_min;
    assign bus.cr_max      = act_cr_max;
    assign bus.cfg_pending = pending;
    assign bus.pix_count   = pix_out;
    assign bus.skin_count  = skin_out;
    assign bus.stat_valid  = stat_vld;
endmodule

// File: tb/tb_skin_frame_ctrl.sv
// Self-checking bench for skin_frame_ctrl (20-bit and 4-bit counter builds).
// Expected frame reports are queued as stimulus is driven, popped on stat_valid.
module tb_skin_frame_ctrl;
    logic clk;
    logic rst;

    skin_frame_ctrl_if #(.CNT_W(20)) bus ();
    skin_frame_ctrl_if #(.CNT_W(4))  bus4 ();

    skin_frame_ctrl #(.CNT_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    skin_frame_ctrl #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        int pix;
        int skin;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    int   n_run;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int n, input int nskin);
        for (int i = 0; i < n; i++) begin
            bus.dval = 1'b1;
            bus.skin = (i < nskin);
            tick();
            // idle gap with skin high must not count
            bus.dval = 1'b0;
            bus.skin = 1'b1;
            if (i % 7 == 3) tick();
        end
        bus.dval = 1'b0;
        bus.skin = 1'b0;
    endtask

    task automatic vs_pulse();
        bus.vs = 1'b1;
        tick();
        bus.vs = 1'b0;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.vs = 0; bus.dval = 0; bus.skin = 0;
        bus4.wr_en = 0; bus4.wr_addr = 0; bus4.wr_data = 0;
        bus4.vs = 0; bus4.dval = 0; bus4.skin = 0;
        rst = 1'b1;
        repeat (3) tick();
        n_run++;
        if ({bus.cb_min, bus.cb_max, bus.cr_min, bus.cr_max}
            !== {8'd85, 8'd127, 8'd132, 8'd155}) begin
            n_fail++;
            $display("FAIL reset_bounds: got %0d %0d %0d %0d want 85 127 132 155",
                     bus.cb_min, bus.cb_max, bus.cr_min, bus.cr_max);
        end
        n_run++;
        if (bus.cfg_pending !== 1'b0 || bus.stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: pending=%b stat_valid=%b want 0 0",
                     bus.cfg_pending, bus.stat_valid);
        end
        n_run++;
        if (bus.pix_count !== 20'd0 || bus.skin_count !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d %0d want 0 0",
                     bus.pix_count, bus.skin_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_count();
        exp_t e;
        // first vs from IDLE: commit only, no report
        vs_pulse();
        n_run++;
        if (bus.stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_vs_report: stat_valid=%b want 0", bus.stat_valid);
        end
        pixels(100, 37);
        sb.push_back('{pix: 100, skin: 37});
        // pixel coincident with vs is not counted
        bus.dval = 1'b1;
        bus.skin = 1'b1;
        vs_pulse();
        n_run++;
        e = sb.pop_front();
        if (bus.stat_valid !== 1'b1 || bus.pix_count !== 20'(e.pix)
            || bus.skin_count !== 20'(e.skin)) begin
            n_fail++;
            $display("FAIL count_report: valid=%b pix=%0d skin=%0d want 1 %0d %0d",
                     bus.stat_valid, bus.pix_count, bus.skin_count, e.pix, e.skin);
        end
        // REPORT cycle: dval/skin ignored, pulse drops
        tick();
        bus.dval = 1'b0;
        bus.skin = 1'b0;
        n_run++;
        if (bus.stat_valid !== 1'b0 || bus.pix_count !== 20'd100
            || bus.skin_count !== 20'd37) begin
            n_fail++;
            $display("FAIL count_hold: valid=%b pix=%0d skin=%0d want 0 100 37",
                     bus.stat_valid, bus.pix_count, bus.skin_count);
        end
    endtask

    task automatic test_shadow_commit();
        exp_t e;
        host_write(2'd1, 8'd120);
        n_run++;
        if (bus.cb_max !== 8'd127 || bus.cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL shadow_hold: cb_max=%0d pending=%b want 127 1",
                     bus.cb_max, bus.cfg_pending);
        end
        pixels(5, 2);
        sb.push_back('{pix: 5, skin: 2});
        vs_pulse();
        n_run++;
        e = sb.pop_front();
        if (bus.stat_valid !== 1'b1 || bus.pix_count !== 20'(e.pix)
            || bus.skin_count !== 20'(e.skin) || bus.cb_max !== 8'd127) begin
            n_fail++;
            $display("FAIL shadow_report: valid=%b pix=%0d skin=%0d cb_max=%0d want 1 %0d %0d 127",
                     bus.stat_valid, bus.pix_count, bus.skin_count, bus.cb_max,
                     e.pix, e.skin);
        end
        tick();
        n_run++;
        if (bus.cb_max !== 8'd120 || bus.cfg_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL shadow_commit: cb_max=%0d pending=%b want 120 0",
                     bus.cb_max, bus.cfg_pending);
        end
    endtask

    task automatic test_report_write();
        exp_t e;
        pixels(3, 3);
        sb.push_back('{pix: 3, skin: 3});
        vs_pulse();
        n_run++;
        e = sb.pop_front();
        if (bus.stat_valid !== 1'b1 || bus.pix_count !== 20'(e.pix)
            || bus.skin_count !== 20'(e.skin)) begin
            n_fail++;
            $display("FAIL rw_report: valid=%b pix=%0d skin=%0d want 1 %0d %0d",
                     bus.stat_valid, bus.pix_count, bus.skin_count, e.pix, e.skin);
        end
        // write during the REPORT (commit) cycle
        host_write(2'd0, 8'd90);
        n_run++;
        if (bus.cb_min !== 8'd85 || bus.cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_defer: cb_min=%0d pending=%b want 85 1",
                     bus.cb_min, bus.cfg_pending);
        end
        sb.push_back('{pix: 0, skin: 0});
        vs_pulse();
        n_run++;
        e = sb.pop_front();
        if (bus.stat_valid !== 1'b1 || bus.pix_count !== 20'(e.pix)
            || bus.skin_count !== 20'(e.skin)) begin
            n_fail++;
            $display("FAIL empty_frame: valid=%b pix=%0d skin=%0d want 1 %0d %0d",
                     bus.stat_valid, bus.pix_count, bus.skin_count, e.pix, e.skin);
        end
        tick();
        n_run++;
        if (bus.cb_min !== 8'd90 || bus.cfg_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_apply: cb_min=%0d pending=%b want 90 0",
                     bus.cb_min, bus.cfg_pending);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        bus4.vs = 1'b1;
        tick();
        bus4.vs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus4.dval = 1'b1;
            bus4.skin = 1'b1;
            tick();
        end
        bus4.dval = 1'b0;
        bus4.skin = 1'b0;
        sb4.push_back('{pix: 15, skin: 15});
        bus4.vs = 1'b1;
        tick();
        bus4.vs = 1'b0;
        n_run++;
        e = sb4.pop_front();
        if (bus4.stat_valid !== 1'b1 || int'(bus4.pix_count) != e.pix
            || int'(bus4.skin_count) != e.skin) begin
            n_fail++;
            $display("FAIL saturate: valid=%b pix=%0d skin=%0d want 1 %0d %0d",
                     bus4.stat_valid, bus4.pix_count, bus4.skin_count, e.pix, e.skin);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   seen;
        host_write(2'd2, 8'd140);
        pixels(7, 1);
        sb.push_back('{pix: 7, skin: 1});
        vs_pulse();
        n_run++;
        e = sb.pop_front();
        if (bus.stat_valid !== 1'b1 || bus.pix_count !== 20'(e.pix)
            || bus.skin_count !== 20'(e.skin)) begin
            n_fail++;
            $display("FAIL pre_rst_report: valid=%b pix=%0d skin=%0d want 1 %0d %0d",
                     bus.stat_valid, bus.pix_count, bus.skin_count, e.pix, e.skin);
        end
        tick();
        n_run++;
        if (bus.cr_min !== 8'd140) begin
            n_fail++;
            $display("FAIL pre_rst_commit: cr_min=%0d want 140", bus.cr_min);
        end
        pixels(50, 20);
        host_write(2'd3, 8'd200);
        rst = 1'b1;
        #2;
        n_run++;
        if ({bus.cb_min, bus.cb_max, bus.cr_min, bus.cr_max}
            !== {8'd85, 8'd127, 8'd132, 8'd155}
            || bus.cfg_pending !== 1'b0 || bus.stat_valid !== 1'b0
            || bus.pix_count !== 20'd0 || bus.skin_count !== 20'd0) begin
            n_fail++;
            $display("FAIL mid_reset: b=%0d %0d %0d %0d pend=%b sv=%b cnt=%0d %0d",
                     bus.cb_min, bus.cb_max, bus.cr_min, bus.cr_max,
                     bus.cfg_pending, bus.stat_valid, bus.pix_count, bus.skin_count);
        end
        tick();
        rst = 1'b0;
        tick();
        vs_pulse();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.stat_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_run++;
        if (seen) begin
            n_fail++;
            $display("FAIL post_rst_vs: stat_valid seen=1 want 0");
        end
        pixels(10, 4);
        sb.push_back('{pix: 10, skin: 4});
        vs_pulse();
        n_run++;
        e = sb.pop_front();
        if (bus.stat_valid !== 1'b1 || bus.pix_count !== 20'(e.pix)
            || bus.skin_count !== 20'(e.skin)) begin
            n_fail++;
            $display("FAIL post_rst_report: valid=%b pix=%0d skin=%0d want 1 %0d %0d",
                     bus.stat_valid, bus.pix_count, bus.skin_count, e.pix, e.skin);
        end
        tick();
        n_run++;
        if (bus.cr_max !== 8'd155 || bus.cr_min !== 8'd132
            || bus.cfg_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL discard_shadow: cr_min=%0d cr_max=%0d pend=%b want 132 155 0",
                     bus.cr_min, bus.cr_max, bus.cfg_pending);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        test_reset();
        test_count();
        test_shadow_commit();
        test_report_write();
        test_saturate();
        test_reset_mid();
        n_run++;
        if (sb.size() != 0 || sb4.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d %0d entries want 0 0",
                     sb.size(), sb4.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
